// File: rtl/axis_vector_player.sv
// axis_vector_player
// On-chip AXI-Stream test-vector player and response checker. Streams
// NUM_VECTORS input frames out of M_AXIS, drains each response frame on
// S_AXIS up to TLAST, and compares every response word against an
// expected table. It reports done/pass/timeout and a saturating error count.
// Both tables are packed parameters: entry i sits at bits [i*CMP_WIDTH +: CMP_WIDTH].
module axis_vector_player #(
    parameter int NUM_IN_WORDS  = 8,
    parameter int NUM_OUT_WORDS = 8,
    parameter int NUM_VECTORS   = 2,
    parameter int CMP_WIDTH     = 8,
    parameter int TIMEOUT_CYC   = 1024,
    parameter logic [NUM_VECTORS*NUM_IN_WORDS*CMP_WIDTH-1:0]  IN_ROM  = '0,
    parameter logic [NUM_VECTORS*NUM_OUT_WORDS*CMP_WIDTH-1:0] EXP_ROM = '0
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    output logic        M_AXIS_TVALID,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    input  logic        S_AXIS_TVALID,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_RECV,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [15:0] NIN      = 16'(NUM_IN_WORDS);
    localparam logic [15:0] NOUT     = 16'(NUM_OUT_WORDS);
    localparam logic [15:0] NVEC     = 16'(NUM_VECTORS);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t state, state_nxt;

    logic [15:0] vec;
    logic [15:0] widx;
    logic [15:0] ridx;
    logic [15:0] wd;
    logic [15:0] err;
    logic        done_r;
    logic        pass_r;
    logic        tmo_r;

    logic [31:0]          in_addr;
    logic [31:0]          exp_addr;
    logic [CMP_WIDTH-1:0] in_word;
    logic [CMP_WIDTH-1:0] exp_word;
    logic                 in_beat;
    logic                 out_beat;
    logic                 last_in;
    logic                 last_vec;
    logic                 wd_fire;
    logic [15:0]          err_inc;
    logic [16:0]          err_sum;
    logic [15:0]          err_nxt;

    // Upper response bits are outside the compared width and deliberately ignored.
    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA[31:CMP_WIDTH];

    // Table lookups, handshakes, watchdog expiry and the next error count.
    always_comb begin
        in_addr  = 32'(vec) * 32'(NUM_IN_WORDS) + 32'(widx);
        exp_addr = 32'(vec) * 32'(NUM_OUT_WORDS) + ((ridx < NOUT) ? 32'(ridx) : 32'd0);
        in_word  = IN_ROM[in_addr*CMP_WIDTH +: CMP_WIDTH];
        exp_word = EXP_ROM[exp_addr*CMP_WIDTH +: CMP_WIDTH];

        in_beat  = (state == S_SEND) && M_AXIS_TREADY;
        out_beat = (state == S_RECV) && S_AXIS_TVALID;
        last_in  = (widx == NIN - 16'd1);
        last_vec = (vec == NVEC - 16'd1);
        wd_fire  = (state == S_RECV) && !S_AXIS_TVALID && (wd == TMO_LAST);

        // Mismatch (or overlong beat) and short-frame penalty land in one update.
        err_inc = 16'd0;
        if (out_beat) begin
            if (ridx < NOUT) begin
                err_inc = (S_AXIS_TDATA[CMP_WIDTH-1:0] != exp_word) ? 16'd1 : 16'd0;
            end else begin
                err_inc = 16'd1;
            end
            if (S_AXIS_TLAST && (ridx + 16'd1 < NOUT)) begin
                err_inc = err_inc + (NOUT - ridx - 16'd1);
            end
        end
        err_sum = {1'b0, err} + {1'b0, err_inc};
        err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Next-state logic and state-decoded stream/status outputs.
    always_comb begin
        state_nxt     = state;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = 32'd0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = 1'b0;
        busy          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SEND;
            end
            S_SEND: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = 32'(in_word);
                M_AXIS_TLAST  = last_in;
                busy          = 1'b1;
                if (in_beat && last_in) state_nxt = S_RECV;
            end
            S_RECV: begin
                S_AXIS_TREADY = 1'b1;
                busy          = 1'b1;
                // The final frame goes straight to DONE so done shows one cycle after TLAST.
                if (out_beat && S_AXIS_TLAST) begin
                    state_nxt = last_vec ? S_DONE : S_NEXT;
                end else if (wd_fire) begin
                    state_nxt = S_DONE;
                end
            end
            S_NEXT: begin
                busy      = 1'b1;
                state_nxt = S_SEND;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Indices, watchdog, error count and sticky result flags.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            vec    <= 16'd0;
            widx   <= 16'd0;
            ridx   <= 16'd0;
            wd     <= 16'd0;
            err    <= 16'd0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            tmo_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vec    <= 16'd0;
                        widx   <= 16'd0;
                        ridx   <= 16'd0;
                        wd     <= 16'd0;
                        err    <= 16'd0;
                        done_r <= 1'b0;
                        pass_r <= 1'b0;
                        tmo_r  <= 1'b0;
                    end
                end
                S_SEND: begin
                    wd <= 16'd0;
                    if (in_beat) widx <= last_in ? 16'd0 : widx + 16'd1;
                end
                S_RECV: begin
                    err <= err_nxt;
                    if (out_beat) begin
                        wd <= 16'd0;
                        // ridx parks at NOUT so every overlong beat keeps counting.
                        if (ridx < NOUT) ridx <= ridx + 16'd1;
                    end else if (!wd_fire) begin
                        wd <= wd + 16'd1;
                    end
                    if (wd_fire) tmo_r <= 1'b1;
                    if (state_nxt == S_DONE) begin
                        done_r <= 1'b1;
                        pass_r <= (err_nxt == 16'd0) && !wd_fire;
                    end
                end
                S_NEXT: begin
                    vec  <= vec + 16'd1;
                    widx <= 16'd0;
                    ridx <= 16'd0;
                    wd   <= 16'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign done      = done_r;
    assign pass      = pass_r;
    assign timeout   = tmo_r;
    assign err_count = err;

endmodule

// File: tb/tb_axis_vector_player.sv
// Bench for axis_vector_player: the bench plays the coprocessor, looping
// source words back as responses with optional stalls, corruption,
// short frames or silence.
module tb_axis_vector_player;

    localparam int NI  = 8;
    localparam int NO  = 8;
    localparam int NV  = 2;
    localparam int CW  = 8;
    localparam int TMO = 1024;

    function automatic logic [7:0] vec_word(input int v, input int w);
        return 8'(v * NI + w + 7);
    endfunction

    function automatic logic [NV*NI*CW-1:0] mk_rom();
        logic [NV*NI*CW-1:0] r;
        r = '0;
        for (int v = 0; v < NV; v++)
            for (int w = 0; w < NI; w++)
                r[(v*NI+w)*CW +: CW] = vec_word(v, w);
        return r;
    endfunction

    localparam logic [NV*NI*CW-1:0] ROM = mk_rom();

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tlast_cyc = 0;

    bit rsp_corrupt = 0;
    bit rsp_short   = 0;
    bit rsp_silent  = 0;
    bit rsp_toggle  = 0;

    logic [8:0]  sb[$];
    logic [7:0]  rq[$];
    logic [8:0]  sb_e;
    int          out_cnt = 0;
    int          fr = 0;
    bit          stall_prev = 0;
    logic [31:0] stall_data;
    logic        stall_last;

    axis_vector_player #(
        .NUM_IN_WORDS (NI),
        .NUM_OUT_WORDS(NO),
        .NUM_VECTORS  (NV),
        .CMP_WIDTH    (CW),
        .TIMEOUT_CYC  (TMO),
        .IN_ROM       (ROM),
        .EXP_ROM      (ROM)
    ) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .start        (start),
        .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TDATA (m_tdata),
        .M_AXIS_TLAST (m_tlast),
        .M_AXIS_TREADY(m_tready),
        .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TDATA (s_tdata),
        .S_AXIS_TLAST (s_tlast),
        .S_AXIS_TREADY(s_tready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: observed stuck expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_m_tvalid"},  32'(m_tvalid),  32'd0);
        chk({tag, "_m_tdata"},   m_tdata,        32'd0);
        chk({tag, "_m_tlast"},   32'(m_tlast),   32'd0);
        chk({tag, "_s_tready"},  32'(s_tready),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_pass"},      32'(pass),      32'd0);
        chk({tag, "_timeout"},   32'(timeout),   32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    // Called at posedge+1; loads the expected source stream and pulses start.
    task automatic do_start(input string tag);
        sb.delete();
        rq.delete();
        fr = 0;
        out_cnt = 0;
        for (int v = 0; v < NV; v++)
            for (int w = 0; w < NI; w++)
                sb.push_back({(w == NI - 1), vec_word(v, w)});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_first_tvalid"}, 32'(m_tvalid),     32'd1);
        chk({tag, "_first_tdata"},  m_tdata,           32'(vec_word(0, 0)));
        chk({tag, "_busy_start"},   32'(busy),         32'd1);
        chk({tag, "_done_clr"},     32'(done),         32'd0);
        chk({tag, "_err_clr"},      32'(err_count),    32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done_in_budget"}, 32'(done === 1'b1), 32'd1);
    endtask

    task automatic check_result(input string tag, input int e, input bit p, input bit t);
        chk({tag, "_done"},      32'(done),      32'd1);
        chk({tag, "_pass"},      32'(pass),      32'(p));
        chk({tag, "_timeout"},   32'(timeout),   32'(t));
        chk({tag, "_err_count"}, 32'(err_count), 32'(e));
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Coprocessor model: loops source words back as response frames.
    always @(negedge clk) begin
        if (rst) begin
            rq.delete();
            out_cnt    = 0;
            fr         = 0;
            stall_prev = 0;
            s_tvalid   = 1'b0;
            s_tdata    = 32'd0;
            s_tlast    = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_tvalid", 32'(m_tvalid), 32'd1);
                chk("hold_tdata",  m_tdata,       stall_data);
                chk("hold_tlast",  32'(m_tlast),  32'(stall_last));
            end
            m_tready = rsp_toggle ? ~m_tready : 1'b1;
            s_tvalid = !rsp_silent && (rq.size() > 0);
            s_tdata  = 32'd0;
            s_tlast  = 1'b0;
            if (s_tvalid) begin
                s_tdata[7:0] = rq[0];
                if (rsp_corrupt && fr == 1 && out_cnt == 3) s_tdata[7:0] = rq[0] ^ 8'h01;
                s_tlast = (rsp_short && fr == 0) ? (out_cnt == 5) : (out_cnt == NO - 1);
            end
            stall_prev = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    chk("src_extra_beat", 32'd1, 32'd0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("src_word",  {23'd0, m_tlast, m_tdata[7:0]}, {23'd0, sb_e});
                    chk("src_upper", {8'd0, m_tdata[31:8]},          32'd0);
                end
                rq.push_back(m_tdata[7:0]);
            end
            if (s_tvalid && s_tready) begin
                void'(rq.pop_front());
                if (s_tlast) begin
                    if (rsp_short && fr == 0) begin
                        repeat (2) if (rq.size() > 0) void'(rq.pop_front());
                    end
                    out_cnt   = 0;
                    fr        = fr + 1;
                    tlast_cyc = cyc + 1;
                end else begin
                    out_cnt = out_cnt + 1;
                end
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean loopback.
        do_start("t1");
        wait_done("t1", 200);
        check_result("t1", 0, 1'b1, 1'b0);
        chk("t1_done_same_edge_as_tlast", 32'(cyc - tlast_cyc), 32'd0);
        chk("t1_s_tready_dropped",        32'(s_tready),        32'd0);
        chk("t1_frames_seen",             32'(fr),              32'd2);
        chk("t1_src_all_sent",            32'(sb.size()),       32'd0);
        @(posedge clk); #1;
        chk("t1_done_sticky", 32'(done), 32'd1);

        // Word 3 of vector 1 returned as 0x13 instead of 0x12.
        rsp_corrupt = 1;
        do_start("t2");
        wait_done("t2", 200);
        check_result("t2", 1, 1'b0, 1'b0);
        rsp_corrupt = 0;
        @(posedge clk); #1;

        // Source stalls every other cycle; a stray start mid-run is ignored.
        rsp_toggle = 1;
        do_start("t3");
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t3", 400);
        check_result("t3", 0, 1'b1, 1'b0);
        chk("t3_src_all_sent", 32'(sb.size()), 32'd0);
        rsp_toggle = 0;
        @(posedge clk); #1;

        // Vector 0 response ends after 6 words: two missing-word errors.
        rsp_short = 1;
        do_start("t4");
        wait_done("t4", 200);
        check_result("t4", 2, 1'b0, 1'b0);
        chk("t4_frames_seen", 32'(fr), 32'd2);
        rsp_short = 0;
        @(posedge clk); #1;

        // Coprocessor never answers: watchdog aborts after TMO idle RECV cycles.
        rsp_silent = 1;
        do_start("t5");
        n = 0;
        while (s_tready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (s_tready === 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_recv_cycles", 32'(n), 32'(TMO));
        check_result("t5", 0, 1'b0, 1'b1);
        chk("t5_vector1_skipped", 32'(sb.size()), 32'(NI));
        rsp_silent = 0;
        @(posedge clk); #1;

        // Reset while word 4 of vector 0 is on the bus, then replay.
        do_start("t6");
        n = 0;
        while (sb.size() > NV * NI - 4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_word4_on_bus", {24'd0, m_tdata[7:0]}, 32'(vec_word(0, 4)));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("t6_after_rst");
        @(posedge clk); #1;
        do_start("t6_replay");
        wait_done("t6_replay", 200);
        check_result("t6_replay", 0, 1'b1, 1'b0);
        chk("t6_src_all_sent", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
